// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: digit count, segment bit
// positions and the active-high hex glyph table.
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 4;

   // Segment bit positions inside a 7-bit pattern (bit0 = a ... bit6 = g)
   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;

   typedef logic [6:0] seg_t;

   // Active-high glyphs for 0..F, bit order g..a
   localparam seg_t HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-glyph lookup; output is always active-high.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/uart_seg7_display.sv
// Shows the two most recent UART bytes as four scanned hex digits and flashes
// digit 0's decimal point for a while after each received byte.
module uart_seg7_display
   import seg7_pkg::*;
#(
   parameter int unsigned CLKS_PER_DIGIT = 50000,
   parameter int unsigned ACT_CLKS       = 5000000,
   parameter bit          ACTIVE_LOW     = 1'b1
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset_n,
   input  logic                  i_RX_DV,
   input  logic [7:0]            i_RX_Byte,
   input  logic                  i_Clear,
   output logic [6:0]            o_Seg,
   output logic                  o_DP,
   output logic [NUM_DIGITS-1:0] o_Dig
);

   localparam int unsigned REF_W = (CLKS_PER_DIGIT > 2) ? $clog2(CLKS_PER_DIGIT) : 1;
   localparam int unsigned ACT_W = $clog2(ACT_CLKS + 1);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(CLKS_PER_DIGIT - 1);
   localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_CLKS);
   // XOR masks that turn active-high values into pin polarity
   localparam logic [6:0]            SEG_INV = {7{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] DIG_INV = {NUM_DIGITS{ACTIVE_LOW}};

   logic [15:0]           history;
   logic [NUM_DIGITS-1:0] valid;
   logic [REF_W-1:0]      refresh_cnt;
   logic [1:0]            scan_idx;
   logic [ACT_W-1:0]      act_cnt;
   logic [3:0]            nibble;
   seg_t                  pattern;
   logic [6:0]            seg_q;
   logic                  dp_q;
   logic [NUM_DIGITS-1:0] dig_q;

   assign nibble = history[{scan_idx, 2'b00} +: 4];

   hex_to_seg7 u_hex (
      .nibble (nibble),
      .seg    (pattern)
   );

   // Byte history and per-digit valid mask; clear wins over a same-cycle byte
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         history <= 16'h0000;
         valid   <= '0;
      end else if (i_Clear) begin
         history <= 16'h0000;
         valid   <= '0;
      end else if (i_RX_DV) begin
         history <= {history[7:0], i_RX_Byte};
         valid   <= {valid[1:0], 2'b11};
      end
   end

   // Activity timer: reload on every byte, otherwise count down and hold at 0
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         act_cnt <= '0;
      end else if (i_Clear) begin
         act_cnt <= '0;
      end else if (i_RX_DV) begin
         act_cnt <= ACT_LOAD;
      end else if (act_cnt != '0) begin
         act_cnt <= act_cnt - ACT_W'(1);
      end
   end

   // Refresh counter and scan index; the index steps on refresh terminal count
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         refresh_cnt <= '0;
         scan_idx    <= 2'd0;
      end else if (refresh_cnt == REF_LAST) begin
         refresh_cnt <= '0;
         scan_idx    <= scan_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + REF_W'(1);
      end
   end

   // Registered pin drivers, built from pre-update history and scan index
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         seg_q <= SEG_INV;
         dp_q  <= ACTIVE_LOW;
         dig_q <= DIG_INV;
      end else begin
         seg_q <= (valid[scan_idx] ? pattern : 7'h00) ^ SEG_INV;
         dp_q  <= ((scan_idx == 2'd0) && (act_cnt != '0)) ^ ACTIVE_LOW;
         dig_q <= (NUM_DIGITS'(1) << scan_idx) ^ DIG_INV;
      end
   end

   assign o_Seg = seg_q;
   assign o_DP  = dp_q;
   assign o_Dig = dig_q;

endmodule

// File: tb/tb_uart_seg7_display.sv
// Randomised self-checking bench for uart_seg7_display against a cycle-level
// reference model built from the display rules (bytes list, edge count).
module tb_uart_seg7_display;

   localparam int unsigned CPD = 4;
   localparam int unsigned ACT = 10;

   logic       clk;
   logic       rst_n;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic       clr;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] dig;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int         edge_no;
   int         nbytes;
   logic [7:0] newest;
   logic [7:0] older;
   int         last_dv;

   logic [6:0] hex_tab [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   uart_seg7_display #(
      .CLKS_PER_DIGIT (CPD),
      .ACT_CLKS       (ACT),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .i_Clock   (clk),
      .i_Reset_n (rst_n),
      .i_RX_DV   (rx_dv),
      .i_RX_Byte (rx_byte),
      .i_Clear   (clr),
      .o_Seg     (seg),
      .o_DP      (dp),
      .o_Dig     (dig)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      edge_no = 0;
      nbytes  = 0;
      newest  = 8'h00;
      older   = 8'h00;
      last_dv = -1000;
   endtask

   // One clock: drive inputs, predict outputs from pre-edge model state, check
   task automatic step(input logic dv, input logic [7:0] b, input logic c);
      int         slot;
      bit         vld;
      logic [3:0] nib;
      logic [6:0] exp_seg;
      logic [3:0] exp_dig;
      logic       exp_dp;
      rx_dv   = dv;
      rx_byte = b;
      clr     = c;
      @(posedge clk);
      edge_no++;
      slot = ((edge_no - 1) / CPD) % 4;
      vld  = (slot < 2) ? (nbytes >= 1) : (nbytes >= 2);
      case (slot)
         0:       nib = newest[3:0];
         1:       nib = newest[7:4];
         2:       nib = older[3:0];
         default: nib = older[7:4];
      endcase
      exp_seg = vld ? ~hex_tab[nib] : 7'h7F;
      exp_dig = ~(4'b0001 << slot);
      exp_dp  = !((slot == 0) && ((edge_no - last_dv) <= ACT));
      if (c) begin
         nbytes  = 0;
         newest  = 8'h00;
         older   = 8'h00;
         last_dv = -1000;
      end else if (dv) begin
         older   = newest;
         newest  = b;
         nbytes  = (nbytes < 2) ? nbytes + 1 : 2;
         last_dv = edge_no;
      end
      #1;
      checks++;
      if (dig !== exp_dig) begin
         errors++;
         $display("FAIL dig edge=%0d got=%h exp=%h", edge_no, dig, exp_dig);
      end
      checks++;
      if (seg !== exp_seg) begin
         errors++;
         $display("FAIL seg edge=%0d got=%h exp=%h", edge_no, seg, exp_seg);
      end
      checks++;
      if (dp !== exp_dp) begin
         errors++;
         $display("FAIL dp edge=%0d got=%b exp=%b", edge_no, dp, exp_dp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic check_inactive(input string name);
      checks++;
      if (seg !== 7'h7F || dp !== 1'b1 || dig !== 4'hF) begin
         errors++;
         $display("FAIL %s got seg=%h dp=%b dig=%h exp seg=7f dp=1 dig=f",
                  name, seg, dp, dig);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      rx_dv   = 1'b0;
      rx_byte = 8'h00;
      clr     = 1'b0;
      #23;
      check_inactive("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_idle();
      idle(32);
   endtask

   task automatic test_single_byte();
      step(1'b1, 8'hA5, 1'b0);
      idle(40);
   endtask

   task automatic test_back_to_back();
      step(1'b1, 8'h12, 1'b0);
      step(1'b1, 8'h3F, 1'b0);
      idle(24);
   endtask

   task automatic test_reload();
      step(1'b1, 8'h5C, 1'b0);
      idle(7);
      step(1'b1, 8'hE0, 1'b0);
      idle(24);
   endtask

   task automatic test_clear_priority();
      step(1'b1, 8'h9B, 1'b0);
      idle(3);
      step(1'b1, 8'hFF, 1'b1);
      idle(24);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(3) == 0), 8'($urandom_range(255)), ($urandom_range(39) == 0));
      end
      idle(16);
   endtask

   task automatic test_async_reset();
      step(1'b1, 8'h7D, 1'b0);
      step(1'b1, 8'h64, 1'b0);
      for (int i = 0; i < 16; i++) begin
         if (((edge_no / CPD) % 4) == 2) break;
         step(1'b0, 8'h00, 1'b0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_inactive("async_reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      check_inactive("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      idle(20);
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_byte();
      test_back_to_back();
      test_reload();
      test_clear_priority();
      test_random();
      test_async_reset();
      rx_dv = 1'b0;
      clr   = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_seg7_display.md
Name: uart_seg7_display

Overview:
- Consumes the byte stream produced by the UART receiver (valid strobe plus byte) and shows the two most recent bytes as four hex digits.
- Drives a time-multiplexed 4-digit 7-segment display on the Cyclone IV board.
- Flashes digit 0's decimal point as a receive-activity indicator.
- Sits directly downstream of the UART receive stage and drives the board pins.

Parameters:
- CLKS_PER_DIGIT, 50000, clocks each digit is enabled per scan slot (1 ms at 50 MHz); legal range ≥2.
- ACT_CLKS, 5000000, clocks the activity DP stays lit after the last received byte (100 ms); legal range ≥1.
- ACTIVE_LOW, 1, 1 = segment/DP/digit outputs active-low (common anode); 0 = active-high.

Ports:
- i_Clock  in  1  system clock; single clock domain.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_RX_DV  in  1  one-cycle byte-valid strobe from the UART receiver.
- i_RX_Byte  in  8  received byte; sampled only when i_RX_DV=1.
- i_Clear  in  1  synchronous clear of the displayed history.
- o_Seg  out  7  segments: bit0=a … bit6=g; polarity per ACTIVE_LOW.
- o_DP  out  1  decimal point; polarity per ACTIVE_LOW.
- o_Dig  out  4  one-hot digit enable: bit0 = rightmost digit; polarity per ACTIVE_LOW.

Behaviour:
- Reset (asynchronous, i_Reset_n=0), regardless of current state:
  - history=16'h0000, valid mask=4'b0000, scan index=0, refresh counter=0, activity counter=0.
  - All outputs inactive: ACTIVE_LOW=1 gives o_Seg=7'h7F, o_DP=1, o_Dig=4'hF.
- History register, 16 bits; digit k shows nibble k.
  - On i_RX_DV=1: history <= {history[7:0], i_RX_Byte}; valid mask <= {mask[1:0], 2'b11}.
  - New byte is on digits 1:0; the previous byte moves to digits 3:2.
- i_Clear=1 (synchronous): history=0, valid mask=0, activity counter=0.
  - i_Clear has priority over i_RX_DV in the same cycle; that byte is dropped.
- Activity counter:
  - Loads ACT_CLKS on i_RX_DV (reloads if already running); otherwise decrements to 0 and holds.
  - DP on digit 0 is lit iff the counter ≠0. DPs of digits 1-3 are always off.
- Scan:
  - Refresh counter runs 0..CLKS_PER_DIGIT-1 and wraps.
  - At terminal count the scan index advances 0→1→2→3→0.
- Outputs are registered, one cycle behind scan index and history:
  - o_Dig = one-hot(scan index).
  - o_Seg = hex pattern of the selected nibble, or all segments off if that digit's valid bit is 0.
  - Leading invalid digits stay blank but their slots are still scanned; period = 4·CLKS_PER_DIGIT.
- Hex patterns (active-high, g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - ACTIVE_LOW=1 inverts all of o_Seg, o_DP and o_Dig.
- Latency: a byte accepted at cycle N is in history at N+1. It appears on o_Seg at the first registered output update for that digit's slot after N+1.
- Simultaneous i_RX_DV and refresh wrap: both take effect; the output register samples the pre-update history that cycle.
- Back-to-back i_RX_DV on consecutive cycles: both bytes accepted; no strobe is dropped.
- No state machine beyond the scan counter; no backpressure, since the UART source cannot stall.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry active-high hex-to-segment constant table;
  - NUM_DIGITS=4;
  - segment bit-index constants (SEG_A..SEG_G).
- Sub-module hex_to_seg7 is combinational: 4-bit nibble in, 7-bit active-high pattern out, table from seg7_pkg. Polarity inversion stays in the top.

Test Plan (CLKS_PER_DIGIT=4, ACT_CLKS=10, ACTIVE_LOW=1):
- Reset then idle 32 cycles → o_Dig cycles E,D,B,7 with 4 cycles per digit; o_Seg=7F throughout; o_DP=1.
- Single byte 8'hA5 on i_RX_DV:
  - digit 0 slot shows o_Seg=~6D=12, digit 1 slot shows ~77=08, digits 2-3 show 7F;
  - o_DP=0 during digit 0 slots for 10 cycles, then 1.
- Bytes 8'h12 then 8'h3F on consecutive cycles → digits 3..0 show 1,2,3,F (inverted 79,24,30,0E); both bytes retained.
- i_RX_DV while activity counter=3 → counter reloads to 10; DP stays lit 10 more cycles.
- i_Clear and i_RX_DV(8'hFF) in the same cycle → all digits blank, o_DP inactive, byte not shown.
- Assert i_Reset_n=0 mid-scan at scan index 2 → outputs go inactive immediately, asynchronously. After release, scan restarts at digit 0 and history is empty.
